cxs_tx_flit_packer: RTL and testbench

//  Parametrised CXS transmit-side flit packer with credit flow control and link FSM.

---
 rtl/cxs_tx_pkg.sv | 46 ++++
 rtl/cxs_tx_fifo.sv | 63 ++++++
 rtl/cxs_tx_flit_packer.sv | 191 +++++++++++++++++++
 tb/tb_cxs_tx_flit_packer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cxs_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cxs_tx_pkg
// Description : Shared types and header layout for the CXS TX flit packer.
//               Provides the link state enumeration, header bit positions
//               and the header builder used by cxs_tx_flit_packer.
// Revision    : 1.0 - initial release
// ============================================================================
package cxs_tx_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        ACTV  = 2'd1,
        RUN   = 2'd2,
        DEACT = 2'd3
    } link_state_e;

    // Header layout (bit positions inside the HDR_W-bit header)
    localparam int c_HDR_MIN_W     = 52;
    localparam int c_HDR_PRCL_LSB  = 49;
    localparam int c_HDR_MPF_LSB   = 47;
    localparam int c_HDR_DFW_LSB   = 45;
    localparam int c_HDR_LAST_BIT  = 44;
    localparam int c_HDR_CNTL_MAXW = 44;

    // Builds the low 52 header bits; dp/cp sit at the top of the header and
    // are placed by the caller because their position depends on HDR_W.
    function automatic logic [c_HDR_MIN_W-1:0] build_hdr(
        input logic [2:0]                 prcltype,
        input logic [1:0]                 maxpktperflit,
        input logic [1:0]                 dataflitwidth,
        input logic                       last,
        input logic [c_HDR_CNTL_MAXW-1:0] cntl
    );
        logic [c_HDR_MIN_W-1:0] h;
        h                                  = '0;
        h[c_HDR_PRCL_LSB +: 3]             = prcltype;
        h[c_HDR_MPF_LSB  +: 2]             = maxpktperflit;
        h[c_HDR_DFW_LSB  +: 2]             = dataflitwidth;
        h[c_HDR_LAST_BIT]                  = last;
        h[c_HDR_CNTL_MAXW-1:0]             = cntl;
        return h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cxs_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cxs_tx_fifo
// Description : Synchronous FIFO, WIDTH x DEPTH (DEPTH power of 2).
//               Ports: cxs_clk, cxs_rst_n (async, active-low), i_push,
//               i_push_data, i_pop, o_pop_data (head, zero when empty),
//               o_full, o_empty, o_count.
//               Push while full is accepted only together with a pop.
// Revision    : 1.0 - initial release
// ============================================================================
module cxs_tx_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 4
) (
    input  logic                       cxs_clk,
    input  logic                       cxs_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_pop_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == c_CW'(DEPTH));
    assign o_count    = r_count;
    assign w_do_pop   = i_pop & ~o_empty;
    assign w_do_push  = i_push & (~o_full | w_do_pop);
    // Zeroing the head when empty keeps the output defined out of reset.
    assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge cxs_clk or negedge cxs_rst_n) begin
        if (!cxs_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            r_count <= r_count + c_CW'(w_do_push) - c_CW'(w_do_pop);
        end
    end

    always_ff @(posedge cxs_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    a_no_overflow: assert property (@(posedge cxs_clk) disable iff (!cxs_rst_n)
        !(i_push && o_full && !i_pop));

endmodule
`default_nettype wire

// File: rtl/cxs_tx_flit_packer.sv
`default_nettype none
// ============================================================================
// Module      : cxs_tx_flit_packer
// Description : CXS transmit flit packer. Accepts credited CXS beats,
//               prepends an HDR_W-bit header (HDR_W = FLIT_W - CXS_DATA_W),
//               buffers flits and drives them to the RX link with
//               tx_valid/rx_ready. Includes the STOP/ACTV/RUN/DEACT link FSM
//               and credit grant/return accounting.
//               Ports: CXS side (activereq/ack, deacthint, valid, data, cntl,
//               last, prcltype, crdgnt, crdrtn), cfg_* header fields,
//               link side (rx_ready, tx_valid, tx_pkt_data), crd_err.
//               Option CXS_TX_PARITY_EN: adds tx_pkt_par, even parity per
//               byte of tx_pkt_data, stored in the FIFO with the flit.
// Revision    : 1.0 - initial release
// ============================================================================
module cxs_tx_flit_packer
    import cxs_tx_pkg::*;
#(
    parameter int CXS_DATA_W = 256,
    parameter int FLIT_W     = 512,
    parameter int CNTL_W     = 14,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_CRD    = 15
) (
    input  logic                  cxs_clk,
    input  logic                  cxs_rst_n,
    input  logic                  cxs_activereq,
    output logic                  cxs_activeack,
    output logic                  cxs_deacthint,
    input  logic                  cxs_valid,
    input  logic [CXS_DATA_W-1:0] cxs_data,
    input  logic [CNTL_W-1:0]     cxs_cntl,
    input  logic                  cxs_last,
    input  logic [2:0]            cxs_prcltype,
    output logic                  cxs_crdgnt,
    input  logic                  cxs_crdrtn,
    input  logic                  cfg_dp,
    input  logic                  cfg_cp,
    input  logic [1:0]            cfg_maxpktperflit,
    input  logic [1:0]            cfg_dataflitwidth,
    input  logic                  rx_ready,
    output logic                  tx_valid,
    output logic [FLIT_W-1:0]     tx_pkt_data,
`ifdef CXS_TX_PARITY_EN
    output logic [FLIT_W/8-1:0]   tx_pkt_par,
`endif
    output logic                  crd_err
);
    localparam int HDR_W    = FLIT_W - CXS_DATA_W;
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH) + 1;
`ifdef CXS_TX_PARITY_EN
    localparam int c_NBYTES = FLIT_W / 8;
    localparam int c_FIFO_W = FLIT_W + c_NBYTES;
`else
    localparam int c_FIFO_W = FLIT_W;
`endif

    localparam logic [1:0] c_ST_STOP  = STOP;
    localparam logic [1:0] c_ST_ACTV  = ACTV;
    localparam logic [1:0] c_ST_RUN   = RUN;
    localparam logic [1:0] c_ST_DEACT = DEACT;

    if (HDR_W < c_HDR_MIN_W) begin : g_chk_hdr
        $error("cxs_tx_flit_packer: FLIT_W - CXS_DATA_W must be >= 52");
    end
    if (CNTL_W > c_HDR_CNTL_MAXW) begin : g_chk_cntl
        $error("cxs_tx_flit_packer: CNTL_W must be <= 44");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("cxs_tx_flit_packer: FIFO_DEPTH must be a power of 2 >= 2");
    end
    if ((MAX_CRD < 1) || (MAX_CRD > 15)) begin : g_chk_crd
        $error("cxs_tx_flit_packer: MAX_CRD must be 1..15");
    end

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_activeack;
    logic                  r_crdgnt;
    logic                  w_gnt_nxt;
    logic [3:0]            r_crd_out;
    logic [3:0]            w_crd_nxt;
    logic                  r_crd_err;
    logic                  w_err_evt;
    logic                  w_acc;
    logic                  w_rtn_ok;
    logic [HDR_W-1:0]      w_hdr;
    logic [FLIT_W-1:0]     w_flit;
    logic [c_FIFO_W-1:0]   w_push_data;
    logic [c_FIFO_W-1:0]   w_pop_data;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic [c_CNT_W-1:0]    w_fifo_cnt;

    // ---------------- header / flit assembly ----------------
    always_comb begin
        w_hdr                   = '0;
        w_hdr[c_HDR_MIN_W-1:0]  = build_hdr(cxs_prcltype, cfg_maxpktperflit,
                                            cfg_dataflitwidth, cxs_last,
                                            c_HDR_CNTL_MAXW'(cxs_cntl));
        // dp/cp are written last so they own the top two header bits.
        w_hdr[HDR_W-1]          = cfg_dp;
        w_hdr[HDR_W-2]          = cfg_cp;
    end
    assign w_flit = {w_hdr, cxs_data};

`ifdef CXS_TX_PARITY_EN
    logic [c_NBYTES-1:0] w_par;
    always_comb begin
        w_par = '0;
        for (int b = 0; b < c_NBYTES; b++) begin
            w_par[b] = ^w_flit[8*b +: 8];
        end
    end
    assign w_push_data = {w_par, w_flit};
    assign tx_pkt_par  = w_pop_data[FLIT_W +: c_NBYTES];
`else
    assign w_push_data = w_flit;
`endif
    assign tx_pkt_data = w_pop_data[FLIT_W-1:0];

    // ---------------- credit accounting ----------------
    // A beat consumes a credit only if one is outstanding. A return is
    // honoured only if a credit is still left after this cycle's beat, so
    // with one credit out a simultaneous beat wins and the return errors.
    assign w_acc     = cxs_valid & (r_crd_out != 4'd0);
    assign w_rtn_ok  = cxs_crdrtn & (r_crd_out > {3'b000, w_acc});
    assign w_err_evt = (cxs_valid & (r_crd_out == 4'd0)) | (cxs_crdrtn & ~w_rtn_ok);
    assign w_crd_nxt = r_crd_out + {3'b000, r_crdgnt} - {3'b000, w_acc} - {3'b000, w_rtn_ok};

    // The grant on the wire now is already committed, so it counts as pending.
    // Issued from the next state so grants are only ever visible in RUN.
    assign w_gnt_nxt = (w_state_nxt == c_ST_RUN)
                     && ((32'(r_crd_out) + 32'(r_crdgnt)) < 32'(MAX_CRD))
                     && ((32'(r_crd_out) + 32'(w_fifo_cnt) + 32'(r_crdgnt)) < 32'(FIFO_DEPTH));

    // ---------------- link FSM ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_STOP:  if (cxs_activereq && rx_ready) w_state_nxt = c_ST_ACTV;
            c_ST_ACTV:  w_state_nxt = cxs_activereq ? c_ST_RUN : c_ST_STOP;
            c_ST_RUN:   if (!cxs_activereq) w_state_nxt = c_ST_DEACT;
            c_ST_DEACT: if ((r_crd_out == 4'd0) && w_empty) w_state_nxt = c_ST_STOP;
            default:    w_state_nxt = c_ST_STOP;
        endcase
    end

    always_ff @(posedge cxs_clk or negedge cxs_rst_n) begin
        if (!cxs_rst_n) begin
            r_state     <= c_ST_STOP;
            r_activeack <= 1'b0;
            r_crdgnt    <= 1'b0;
            r_crd_out   <= 4'd0;
            r_crd_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_activeack <= (w_state_nxt == c_ST_RUN) || (w_state_nxt == c_ST_DEACT);
            r_crdgnt    <= w_gnt_nxt;
            r_crd_out   <= w_crd_nxt;
            if (w_err_evt) r_crd_err <= 1'b1;
        end
    end

    // ---------------- flit buffer ----------------
    assign w_pop = ~w_empty & rx_ready;

    cxs_tx_fifo #(
        .WIDTH (c_FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .cxs_clk     (cxs_clk),
        .cxs_rst_n   (cxs_rst_n),
        .i_push      (w_acc),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_fifo_cnt)
    );

    assign tx_valid      = ~w_empty;
    assign cxs_activeack = r_activeack;
    assign cxs_crdgnt    = r_crdgnt;
    assign cxs_deacthint = (r_state == c_ST_RUN) & w_full & ~rx_ready;
    assign crd_err       = r_crd_err;

endmodule
`default_nettype wire

// File: tb/tb_cxs_tx_flit_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cxs_tx_flit_packer
// Description : Self-checking bench for cxs_tx_flit_packer. Two instances
//               (512-bit and 1024-bit flits) share one stimulus stream and
//               are compared against a transaction-level reference model
//               (credit counter, link state, queue of expected flits).
//               Honours CXS_TX_PARITY_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cxs_tx_flit_packer;
    localparam int DW1 = 256, FW1 = 512, DW2 = 512, FW2 = 1024;
    localparam int CW = 14, DEPTH = 4, MAXC = 15;
    localparam int ST_STOP = 0, ST_ACTV = 1, ST_RUN = 2, ST_DEACT = 3;

    logic cxs_clk = 1'b0;
    logic cxs_rst_n = 1'b0;
    logic activereq, rx_ready, cxs_valid, cxs_last, cxs_crdrtn, cfg_dp, cfg_cp;
    logic [2:0]     prcl;
    logic [1:0]     cfg_mpf, cfg_dfw;
    logic [CW-1:0]  cntl;
    logic [DW2-1:0] data2;

    logic ack1, dhint_n, gnt1, txv1, err1;
    logic ack2, dhint_w, gnt2, txv2, err2;
    logic [FW1-1:0] pkt1;
    logic [FW2-1:0] pkt2;
`ifdef CXS_TX_PARITY_EN
    logic [FW1/8-1:0] par1;
    logic [FW2/8-1:0] par2;
`endif

    always #5 cxs_clk = ~cxs_clk;

    cxs_tx_flit_packer #(.CXS_DATA_W(DW1), .FLIT_W(FW1), .CNTL_W(CW),
                         .FIFO_DEPTH(DEPTH), .MAX_CRD(MAXC)) dut (
        .cxs_clk(cxs_clk), .cxs_rst_n(cxs_rst_n),
        .cxs_activereq(activereq), .cxs_activeack(ack1), .cxs_deacthint(dhint_n),
        .cxs_valid(cxs_valid), .cxs_data(data2[DW1-1:0]), .cxs_cntl(cntl),
        .cxs_last(cxs_last), .cxs_prcltype(prcl), .cxs_crdgnt(gnt1),
        .cxs_crdrtn(cxs_crdrtn), .cfg_dp(cfg_dp), .cfg_cp(cfg_cp),
        .cfg_maxpktperflit(cfg_mpf), .cfg_dataflitwidth(cfg_dfw),
        .rx_ready(rx_ready), .tx_valid(txv1), .tx_pkt_data(pkt1),
`ifdef CXS_TX_PARITY_EN
        .tx_pkt_par(par1),
`endif
        .crd_err(err1));

    cxs_tx_flit_packer #(.CXS_DATA_W(DW2), .FLIT_W(FW2), .CNTL_W(CW),
                         .FIFO_DEPTH(DEPTH), .MAX_CRD(MAXC)) dut2 (
        .cxs_clk(cxs_clk), .cxs_rst_n(cxs_rst_n),
        .cxs_activereq(activereq), .cxs_activeack(ack2), .cxs_deacthint(dhint_w),
        .cxs_valid(cxs_valid), .cxs_data(data2), .cxs_cntl(cntl),
        .cxs_last(cxs_last), .cxs_prcltype(prcl), .cxs_crdgnt(gnt2),
        .cxs_crdrtn(cxs_crdrtn), .cfg_dp(cfg_dp), .cfg_cp(cfg_cp),
        .cfg_maxpktperflit(cfg_mpf), .cfg_dataflitwidth(cfg_dfw),
        .rx_ready(rx_ready), .tx_valid(txv2), .tx_pkt_data(pkt2),
`ifdef CXS_TX_PARITY_EN
        .tx_pkt_par(par2),
`endif
        .crd_err(err2));

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [FW2-1:0] f1;
        logic [FW2-1:0] f2;
    } flit_t;

    flit_t q[$];
    int    m_crd, m_state, n_cmp, n_mis;
    bit    m_err, m_gnt;

    task automatic chk(input string tag, input logic [FW2-1:0] obs, input logic [FW2-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW2-1:0] exp_flit(input int dw, input int fw, input logic [DW2-1:0] d);
        logic [FW2-1:0] f;
        f = '0;
        for (int i = 0; i < dw; i++) f[i] = d[i];
        for (int i = 0; i < CW; i++) f[dw+i] = cntl[i];
        f[dw+44] = cxs_last;
        f[dw+45] = cfg_dfw[0];
        f[dw+46] = cfg_dfw[1];
        f[dw+47] = cfg_mpf[0];
        f[dw+48] = cfg_mpf[1];
        f[dw+49] = prcl[0];
        f[dw+50] = prcl[1];
        f[dw+51] = prcl[2];
        f[fw-1]  = cfg_dp;
        f[fw-2]  = cfg_cp;
        return f;
    endfunction

    function automatic logic [FW2/8-1:0] exp_par(input logic [FW2-1:0] f, input int nb);
        logic [FW2/8-1:0] p;
        p = '0;
        for (int b = 0; b < nb; b++) begin
            int ones = 0;
            for (int k = 0; k < 8; k++) ones += int'(f[8*b+k]);
            p[b] = (ones % 2) != 0;
        end
        return p;
    endfunction

    task automatic reset_model();
        q.delete();
        m_crd = 0; m_state = ST_STOP; m_err = 1'b0; m_gnt = 1'b0;
    endtask

    // Checks this cycle's outputs, then advances the model past the next edge.
    task automatic model_eval();
        int  acc, rtn, nxt;
        bit  ngnt;
        bit  act;
        act = (m_state == ST_RUN) || (m_state == ST_DEACT);
        chk("activeack", ack1, act);
        chk("activeack_w", ack2, act);
        chk("tx_valid", txv1, q.size() > 0);
        chk("tx_valid_w", txv2, q.size() > 0);
        chk("deacthint", dhint_n, (m_state == ST_RUN) && (q.size() == DEPTH) && !rx_ready);
        chk("deacthint_w", dhint_w, (m_state == ST_RUN) && (q.size() == DEPTH) && !rx_ready);
        chk("crdgnt", gnt1, m_gnt);
        chk("crdgnt_w", gnt2, m_gnt);
        chk("crd_err", err1, m_err);
        chk("crd_err_w", err2, m_err);
        if (q.size() > 0) begin
            chk("head_data", pkt1, q[0].f1);
            chk("head_data_w", pkt2, q[0].f2);
`ifdef CXS_TX_PARITY_EN
            chk("head_par", par1, exp_par(q[0].f1, FW1/8));
            chk("head_par_w", par2, exp_par(q[0].f2, FW2/8));
`endif
        end
        acc = (cxs_valid && m_crd > 0) ? 1 : 0;
        rtn = (cxs_crdrtn && (m_crd - acc) > 0) ? 1 : 0;
        if ((cxs_valid && m_crd == 0) || (cxs_crdrtn && rtn == 0)) m_err = 1'b1;
        nxt = m_state;
        case (m_state)
            ST_STOP:  if (activereq && rx_ready) nxt = ST_ACTV;
            ST_ACTV:  nxt = activereq ? ST_RUN : ST_STOP;
            ST_RUN:   if (!activereq) nxt = ST_DEACT;
            default:  if (m_crd == 0 && q.size() == 0) nxt = ST_STOP;
        endcase
        ngnt = (nxt == ST_RUN) && (m_crd + int'(m_gnt) < MAXC)
            && (m_crd + q.size() + int'(m_gnt) < DEPTH);
        if (q.size() > 0 && rx_ready) void'(q.pop_front());
        if (acc != 0) q.push_back('{f1: exp_flit(DW1, FW1, data2), f2: exp_flit(DW2, FW2, data2)});
        m_crd   = m_crd + int'(m_gnt) - acc - rtn;
        m_gnt   = ngnt;
        m_state = nxt;
    endtask

    task automatic cycle();
        @(negedge cxs_clk);
        model_eval();
        @(posedge cxs_clk);
        #1;
    endtask

    task automatic idle();
        cxs_valid = 1'b0; cxs_crdrtn = 1'b0;
    endtask

    task automatic rand_beat();
        for (int k = 0; k < DW2/32; k++) data2[32*k +: 32] = $urandom;
        cntl      = CW'($urandom);
        cxs_last  = 1'($urandom);
        prcl      = 3'($urandom);
        cxs_valid = 1'b1;
    endtask

    task automatic do_reset();
        cxs_rst_n = 1'b0;
        #1;
        chk("rst_tx_valid", txv1, 1'b0);
        chk("rst_tx_valid_w", txv2, 1'b0);
        chk("rst_crd_out", dut.r_crd_out, 4'd0);
        chk("rst_crdgnt", gnt1, 1'b0);
        chk("rst_activeack", ack1, 1'b0);
        chk("rst_crd_err", err1, 1'b0);
        reset_model();
        repeat (2) @(posedge cxs_clk);
        @(negedge cxs_clk);
        cxs_rst_n = 1'b1;
        @(posedge cxs_clk);
        #1;
    endtask

    task automatic activate(input int want_crd);
        bit ok;
        ok = 1'b0;
        activereq = 1'b1; rx_ready = 1'b1; idle();
        for (int i = 0; i < 30 && !ok; i++) begin
            cycle();
            ok = (m_crd >= want_crd) && (ack1 == 1'b1);
        end
        chk("activate_done", ok, 1'b1);
    endtask

    initial begin
        int  gcount;
        bit  reached;
        n_cmp = 0; n_mis = 0;
        activereq = 1'b0; rx_ready = 1'b0; idle();
        cfg_dp = 1'b1; cfg_cp = 1'b0; cfg_mpf = 2'd2; cfg_dfw = 2'd1;
        prcl = 3'd0; cntl = '0; cxs_last = 1'b0; data2 = '0;
        reset_model();

        // Reset state
        #12;
        chk("reset_ack", ack1, 1'b0);
        chk("reset_gnt", gnt1, 1'b0);
        chk("reset_txv", txv1, 1'b0);
        chk("reset_hint", dhint_n, 1'b0);
        chk("reset_err", err1, 1'b0);
        chk("reset_data", pkt1, '0);
        @(negedge cxs_clk);
        cxs_rst_n = 1'b1;
        @(posedge cxs_clk);
        #1;

        // Activation: ack two cycles later, exactly FIFO_DEPTH grants
        activereq = 1'b1; rx_ready = 1'b1;
        gcount = 0;
        repeat (10) begin
            cycle();
            if (gnt1) gcount++;
        end
        chk("startup_grants", gcount, DEPTH);
        chk("grants_stop", gnt1, 1'b0);

        // Fill FIFO with RX stalled, then drain in order
        rx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rand_beat();
            if (i == 0) data2 = '1;
            if (i == 1) data2[7:0] = 8'h07;
            cycle();
        end
        idle();
        cycle();
        chk("full_deacthint", dhint_n, 1'b1);
        chk("full_no_grant", gnt1, 1'b0);
        chk("full_count", q.size(), DEPTH);
        chk("wide_all_ones", pkt2[DW2-1:0], {DW2{1'b1}});
        chk("wide_dp_bit", pkt2[FW2-1], cfg_dp);
`ifdef CXS_TX_PARITY_EN
        chk("par_all_ones", par1[DW1/8-1:0], '0);
`endif
        rx_ready = 1'b1;
        repeat (DEPTH + 2) cycle();
        chk("drained", txv1, 1'b0);

        // Randomized traffic
        cfg_cp = 1'b1; cfg_mpf = 2'($urandom); cfg_dfw = 2'($urandom);
        repeat (400) begin
            idle();
            if (m_crd > 0 && ($urandom % 2) == 1) rand_beat();
            if (m_crd > int'(cxs_valid) && ($urandom % 8) == 0) cxs_crdrtn = 1'b1;
            rx_ready = ($urandom % 4) != 0;
            cycle();
        end

        // Deactivate; one simultaneous beat+return at one credit out
        idle();
        activereq = 1'b0; rx_ready = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 60 && !reached; i++) begin
            idle();
            if (m_crd == 1 && !m_err) begin
                rand_beat();
                cxs_crdrtn = 1'b1;
            end else if (m_crd > 0) begin
                cxs_crdrtn = 1'b1;
            end
            cycle();
            reached = (m_state == ST_STOP) && (ack1 == 1'b0);
        end
        idle();
        chk("deact_to_stop", reached, 1'b1);
        chk("sim_rtn_err", err1, 1'b1);
        cycle();

        // Beat with zero credits is dropped and flags a sticky error
        do_reset();
        rand_beat();
        cycle();
        idle();
        cycle();
        chk("drop_no_txv", txv1, 1'b0);
        chk("drop_err", err1, 1'b1);
        repeat (3) cycle();
        chk("drop_err_held", err1, 1'b1);

        // Credit return with zero credits flags an error
        do_reset();
        cxs_crdrtn = 1'b1;
        cycle();
        idle();
        cycle();
        chk("rtn_underflow_err", err1, 1'b1);

        // Reset with flits queued discards them immediately
        do_reset();
        activate(3);
        rx_ready = 1'b0;
        repeat (3) begin
            rand_beat();
            cycle();
        end
        idle();
        cycle();
        chk("queued_three", q.size(), 3);
        chk("queued_txv", txv1, 1'b1);
        do_reset();
        repeat (2) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
